rob_unit: RTL and testbench
===========================

ROB_UNIT -- requirements
Module: rob_unit

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 2, rename lanes allocated per cycle.
REQ-002 SHALL have parameter COMMIT_WIDTH, default 2, max entries retired per cycle.
REQ-003 SHALL have parameter WB_PORTS, default 2, completion write ports.
REQ-004 SHALL have parameter ROB_DEPTH, default 16, entries, power of two; preg_addr_t width = log2(ROB_DEPTH).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port instr, input, FETCH_WIDTH x {valid, src1, src2, dst (creg_addr_t), pc (word_t), ctl (control_t)}, renamed instructions from renaming stage.
REQ-008 SHALL have port psrc, output, FETCH_WIDTH x preg_addr_t, ROB index assigned to each lane.
REQ-009 SHALL have port alloc_ready, output, 1, ROB can accept a full group this cycle.
REQ-010 SHALL have ports wb_valid, wb_preg, wb_data, input, WB_PORTS x {1, preg_addr_t, word_t}, execution completion.
REQ-011 SHALL have port flush, input, 1, discard all in-flight entries.
REQ-012 SHALL have port retire, output, COMMIT_WIDTH x {valid, data, ctl, dst, preg}, in-order commit to RAT.

Function
REQ-013 SHALL hold per entry: valid, complete, dst, pc, ctl, data; plus head, tail pointers and count (0..ROB_DEPTH).
REQ-014 SHALL drive alloc_ready = 1 iff ROB_DEPTH - count >= FETCH_WIDTH (all-or-nothing group).
REQ-015 SHALL assign psrc[i] = (tail + number of valid lanes below i) mod ROB_DEPTH, combinationally; invalid lanes consume no entry.
REQ-016 SHALL, on an edge with alloc_ready=1, flush=0, write each valid lane at its psrc with valid=1, complete=0, and advance tail by the valid-lane count.
REQ-017 SHALL ignore instr entirely when alloc_ready=0; renaming stage stalls and holds instr.
REQ-018 SHALL, on an edge with wb_valid[k]=1 and entry wb_preg[k] valid, set complete=1 and data=wb_data[k]; writes to invalid entries are dropped.
REQ-019 SHALL, for two wb ports hitting one index same cycle, let the higher port number win.
REQ-020 SHALL drive retire[0].valid = head entry valid and complete; retire[j].valid = retire[j-1].valid and entry head+j valid and complete (no skipping).
REQ-021 SHALL drive retire[j].preg = (head+j) mod ROB_DEPTH and data/ctl/dst from that entry; retirement is unconditionally accepted.
REQ-022 SHALL, at the edge, clear retired entries' valid, advance head by retired count, and set count_next = count + allocated - retired; simultaneous alloc and retire legal.
REQ-023 SHALL make a completing entry retirable no earlier than the cycle after its wb edge (min wb-to-retire latency 1 cycle).
REQ-024 SHALL wrap head/tail modulo ROB_DEPTH; full (count=ROB_DEPTH) and empty (count=0) distinguished by count, not pointer equality.
REQ-025 SHALL, when flush=1, force all retire[].valid=0 that cycle, drop same-cycle alloc and wb, and at the edge clear all valid/complete, head=tail=0, count=0.

Reset
REQ-026 SHALL, on reset=1 at an edge, set head=tail=0, count=0, all entry valid/complete=0; priority over flush, alloc, wb.
REQ-027 SHALL present after reset: alloc_ready=1, all retire[].valid=0, psrc[0]=0, psrc[1]=1 (both lanes valid).
REQ-028 SHALL treat reset mid-operation identically to REQ-026; outstanding entries are lost without retirement.

Verification
REQ-029 Alloc 2 lanes (dst 5,6) after reset, wb preg 1 then preg 0 on later cycles -> no retire until preg 0 complete; next cycle retire[0].preg=0, retire[1].preg=1 both valid, count 0.
REQ-030 Allocate 8 full groups without wb -> count=16, alloc_ready=0; 9th group ignored, tail unchanged at 0.
REQ-031 Fill to 15 entries with head=15 (wrapped), wb all -> retire preg 15 then 0 in same cycle; pointers wrap correctly.
REQ-032 Same cycle: retire 2 and alloc 2 at count=14 -> count stays 14, alloc_ready reflects pre-edge count (1 after 14->16 would not occur).
REQ-033 Flush with 6 entries, 2 complete at head, alloc and wb active -> retire valid 0 that cycle; next cycle count=0, psrc[0]=0.
REQ-034 Lane0 invalid, lane1 valid at tail=3 -> psrc[1]=3, tail becomes 4; wb to invalid preg 9 -> no state change.

Source files
------------

// File: rtl/rob_unit.sv
// Reorder buffer.
// Allocates up to FETCH_WIDTH renamed instructions per cycle into a circular
// buffer, marks entries complete from WB_PORTS write-back ports, and retires
// up to COMMIT_WIDTH completed entries per cycle, strictly in program order.
// The ROB index of an entry doubles as its physical register tag (psrc/preg).

package rob_pkg;
    localparam int CREG_W = 5;
    localparam int WORD_W = 32;
    localparam int CTL_W  = 8;

    typedef logic [CREG_W-1:0] creg_addr_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CTL_W-1:0]  control_t;

    typedef struct packed {
        logic       valid;
        creg_addr_t src1;
        creg_addr_t src2;
        creg_addr_t dst;
        word_t      pc;
        control_t   ctl;
    } instr_t;
endpackage

// Handshake summary:
//   alloc: the group in instr is taken on a rising edge when alloc_ready=1 and
//          flush=0. Allocation is all-or-nothing; with alloc_ready=0 the rename
//          stage holds instr unchanged and nothing is consumed.
//   retire: retire_valid[j] is an offer that is always accepted; the entries
//          shown leave the ROB at the next rising edge (never under flush).
module rob_unit
    import rob_pkg::*;
#(
    parameter int FETCH_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int WB_PORTS     = 2,
    parameter int ROB_DEPTH    = 16
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  instr_t     [FETCH_WIDTH-1:0]                    instr,
    output logic       [FETCH_WIDTH-1:0][$clog2(ROB_DEPTH)-1:0] psrc,
    output logic                                            alloc_ready,
    input  logic       [WB_PORTS-1:0]                       wb_valid,
    input  logic       [WB_PORTS-1:0][$clog2(ROB_DEPTH)-1:0] wb_preg,
    input  word_t      [WB_PORTS-1:0]                       wb_data,
    input  logic                                            flush,
    output logic       [COMMIT_WIDTH-1:0]                   retire_valid,
    output word_t      [COMMIT_WIDTH-1:0]                   retire_data,
    output control_t   [COMMIT_WIDTH-1:0]                   retire_ctl,
    output creg_addr_t [COMMIT_WIDTH-1:0]                   retire_dst,
    output logic       [COMMIT_WIDTH-1:0][$clog2(ROB_DEPTH)-1:0] retire_preg,
    output logic       [$clog2(ROB_DEPTH)-1:0]              dbg_head,
    output logic       [$clog2(ROB_DEPTH)-1:0]              dbg_tail,
    output logic       [$clog2(ROB_DEPTH):0]                dbg_count,
    output word_t                                           dbg_head_pc
);

    localparam int PREG_W = $clog2(ROB_DEPTH);
    localparam int CNT_W  = PREG_W + 1;

    typedef logic [PREG_W-1:0] preg_addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t DEPTH_C = CNT_W'(ROB_DEPTH);
    localparam cnt_t FW_C    = CNT_W'(FETCH_WIDTH);
    localparam cnt_t ONE_C   = CNT_W'(1);

    // Pointers and occupancy; count disambiguates full from empty.
    preg_addr_t head;
    preg_addr_t tail;
    cnt_t       count;

    // Per-entry state.
    logic [ROB_DEPTH-1:0] ent_valid;
    logic [ROB_DEPTH-1:0] ent_complete;
    creg_addr_t           ent_dst  [ROB_DEPTH];
    word_t                ent_pc   [ROB_DEPTH];
    control_t             ent_ctl  [ROB_DEPTH];
    word_t                ent_data [ROB_DEPTH];

    cnt_t free_cnt;
    cnt_t lane_offs;
    cnt_t alloc_cnt;
    cnt_t retire_cnt;
    logic alloc_fire;
    logic retire_chain;
    logic unused_srcs;

    // Allocation: space check and per-lane index assignment.
    // Invalid lanes take no slot, so later lanes slide down onto tail.
    always_comb begin
        free_cnt    = DEPTH_C - count;
        alloc_ready = (free_cnt >= FW_C);
        alloc_fire  = alloc_ready && !flush;
        lane_offs   = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            psrc[i] = tail + lane_offs[PREG_W-1:0];
            if (instr[i].valid) begin
                lane_offs = lane_offs + ONE_C;
            end
        end
        alloc_cnt = alloc_fire ? lane_offs : '0;
    end

    // Retirement: contiguous run of valid+complete entries from head.
    // The j < count guard keeps a wide commit from lapping the buffer.
    always_comb begin
        retire_chain = !flush;
        retire_cnt   = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            retire_preg[j]  = head + PREG_W'(j);
            retire_chain    = retire_chain
                              && ent_valid[retire_preg[j]]
                              && ent_complete[retire_preg[j]]
                              && (CNT_W'(j) < count);
            retire_valid[j] = retire_chain;
            retire_data[j]  = ent_data[retire_preg[j]];
            retire_ctl[j]   = ent_ctl[retire_preg[j]];
            retire_dst[j]   = ent_dst[retire_preg[j]];
            if (retire_chain) begin
                retire_cnt = retire_cnt + ONE_C;
            end
        end
    end

    // Source operand tags are carried by instr but not needed inside the ROB.
    always_comb begin
        unused_srcs = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            unused_srcs = unused_srcs ^ (^instr[i].src1) ^ (^instr[i].src2);
        end
    end

    // Control state: pointers, count, valid/complete flags.
    // Ordering inside the edge: write-back only hits entries valid before the
    // edge, retire clears after it, and allocation targets free slots, so the
    // three updates never fight over one entry.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_valid    <= '0;
            ent_complete <= '0;
        end else begin
            for (int k = 0; k < WB_PORTS; k++) begin
                if (wb_valid[k] && ent_valid[wb_preg[k]]) begin
                    ent_complete[wb_preg[k]] <= 1'b1;
                end
            end
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (retire_valid[j]) begin
                    ent_valid[retire_preg[j]]    <= 1'b0;
                    ent_complete[retire_preg[j]] <= 1'b0;
                end
            end
            if (alloc_fire) begin
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    if (instr[i].valid) begin
                        ent_valid[psrc[i]]    <= 1'b1;
                        ent_complete[psrc[i]] <= 1'b0;
                    end
                end
            end
            head  <= head + retire_cnt[PREG_W-1:0];
            tail  <= tail + alloc_cnt[PREG_W-1:0];
            count <= count + alloc_cnt - retire_cnt;
        end
    end

    // Payload storage: no reset needed, meaning is gated by valid/complete.
    // Later write-back ports overwrite earlier ones on the same index.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            for (int k = 0; k < WB_PORTS; k++) begin
                if (wb_valid[k] && ent_valid[wb_preg[k]]) begin
                    ent_data[wb_preg[k]] <= wb_data[k];
                end
            end
            if (alloc_fire) begin
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    if (instr[i].valid) begin
                        ent_dst[psrc[i]] <= instr[i].dst;
                        ent_pc[psrc[i]]  <= instr[i].pc;
                        ent_ctl[psrc[i]] <= instr[i].ctl;
                    end
                end
            end
        end
    end

    // Debug visibility of internal pointers and the oldest instruction's pc.
    always_comb begin
        dbg_head    = head;
        dbg_tail    = tail;
        dbg_count   = count;
        dbg_head_pc = ent_pc[head];
    end

endmodule

// File: tb/tb_rob_unit.sv
// Directed testbench for rob_unit with hand-computed expectations.
module tb_rob_unit;
    import rob_pkg::*;

    logic                       clk;
    logic                       reset;
    instr_t     [1:0]           instr;
    logic       [1:0][3:0]      psrc;
    logic                       alloc_ready;
    logic       [1:0]           wb_valid;
    logic       [1:0][3:0]      wb_preg;
    word_t      [1:0]           wb_data;
    logic                       flush;
    logic       [1:0]           retire_valid;
    word_t      [1:0]           retire_data;
    control_t   [1:0]           retire_ctl;
    creg_addr_t [1:0]           retire_dst;
    logic       [1:0][3:0]      retire_preg;
    logic       [3:0]           dbg_head;
    logic       [3:0]           dbg_tail;
    logic       [4:0]           dbg_count;
    word_t                      dbg_head_pc;

    int n_tests = 0;
    int n_fail  = 0;

    rob_unit #(
        .FETCH_WIDTH (2),
        .COMMIT_WIDTH(2),
        .WB_PORTS    (2),
        .ROB_DEPTH   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .psrc        (psrc),
        .alloc_ready (alloc_ready),
        .wb_valid    (wb_valid),
        .wb_preg     (wb_preg),
        .wb_data     (wb_data),
        .flush       (flush),
        .retire_valid(retire_valid),
        .retire_data (retire_data),
        .retire_ctl  (retire_ctl),
        .retire_dst  (retire_dst),
        .retire_preg (retire_preg),
        .dbg_head    (dbg_head),
        .dbg_tail    (dbg_tail),
        .dbg_count   (dbg_count),
        .dbg_head_pc (dbg_head_pc)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        instr    = '0;
        wb_valid = '0;
        wb_preg  = '0;
        wb_data  = '0;
        flush    = 1'b0;
    endtask

    task automatic lane(input int i, input logic v, input logic [4:0] d, input logic [31:0] pc);
        instr[i].valid = v;
        instr[i].src1  = d + 5'd1;
        instr[i].src2  = d + 5'd2;
        instr[i].dst   = d;
        instr[i].pc    = pc;
        instr[i].ctl   = {3'b101, d};
    endtask

    task automatic wb(input int k, input logic [3:0] p, input logic [31:0] d);
        wb_valid[k] = 1'b1;
        wb_preg[k]  = p;
        wb_data[k]  = d;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc2(input logic [4:0] d0, input logic [4:0] d1);
        lane(0, 1'b1, d0, 32'h1000 + {27'd0, d0});
        lane(1, 1'b1, d1, 32'h1000 + {27'd0, d1});
        tick();
        clr();
    endtask

    initial begin
        reset = 1'b1;
        clr();
        tick();
        tick();
        reset = 1'b0;

        // Reset state with both lanes valid
        lane(0, 1'b1, 5'd1, 32'h0);
        lane(1, 1'b1, 5'd2, 32'h4);
        settle();
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_retire_valid", retire_valid, 0);
        check("rst_psrc0", psrc[0], 0);
        check("rst_psrc1", psrc[1], 1);
        check("rst_count", dbg_count, 0);
        clr();

        // Out-of-order completion, in-order retirement
        lane(0, 1'b1, 5'd5, 32'h100);
        lane(1, 1'b1, 5'd6, 32'h104);
        tick();
        clr();
        settle();
        check("ooo_count2", dbg_count, 2);
        check("ooo_tail2", dbg_tail, 2);
        check("ooo_head_pc", dbg_head_pc, 32'h100);
        wb(0, 4'd1, 32'hAAAA);
        tick();
        clr();
        settle();
        check("ooo_no_retire_p1", retire_valid, 0);
        wb(1, 4'd0, 32'hBBBB);
        settle();
        check("ooo_wb_latency", retire_valid, 0);
        tick();
        clr();
        settle();
        check("ooo_retire_valid", retire_valid, 2'b11);
        check("ooo_retire_preg0", retire_preg[0], 0);
        check("ooo_retire_preg1", retire_preg[1], 1);
        check("ooo_retire_data0", retire_data[0], 32'hBBBB);
        check("ooo_retire_data1", retire_data[1], 32'hAAAA);
        check("ooo_retire_dst0", retire_dst[0], 5);
        check("ooo_retire_dst1", retire_dst[1], 6);
        check("ooo_retire_ctl1", retire_ctl[1], 8'hA6);
        tick();
        settle();
        check("ooo_count0", dbg_count, 0);
        check("ooo_head2", dbg_head, 2);
        check("ooo_idle_retire", retire_valid, 0);

        // Sparse lanes, invalid write-back, port priority
        do_reset();
        alloc2(5'd1, 5'd2);
        lane(0, 1'b1, 5'd3, 32'h200);
        tick();
        clr();
        lane(0, 1'b0, 5'd0, 32'h0);
        lane(1, 1'b1, 5'd4, 32'h204);
        settle();
        check("sparse_psrc0", psrc[0], 3);
        check("sparse_psrc1", psrc[1], 3);
        tick();
        clr();
        settle();
        check("sparse_tail4", dbg_tail, 4);
        check("sparse_count4", dbg_count, 4);
        wb(0, 4'd9, 32'hDEAD);
        tick();
        clr();
        settle();
        check("badwb_count", dbg_count, 4);
        check("badwb_retire", retire_valid, 0);
        wb(0, 4'd0, 32'h11);
        wb(1, 4'd0, 32'h22);
        tick();
        clr();
        settle();
        check("prio_retire_valid", retire_valid, 2'b01);
        check("prio_retire_data", retire_data[0], 32'h22);
        check("prio_retire_dst", retire_dst[0], 1);
        tick();
        settle();
        check("prio_count3", dbg_count, 3);
        check("prio_head1", dbg_head, 1);

        // Wrap: bring head to 15, refill 15, retire 15 and 0 together
        do_reset();
        for (int g = 0; g < 7; g++) alloc2(5'(2 * g), 5'(2 * g + 1));
        lane(0, 1'b1, 5'd14, 32'h300);
        tick();
        clr();
        settle();
        check("wrap_fill_tail", dbg_tail, 15);
        check("wrap_fill_count", dbg_count, 15);
        for (int k = 0; k < 8; k++) begin
            wb(0, 4'(2 * k), 32'(k));
            wb(1, 4'(2 * k + 1), 32'(k));
            tick();
            clr();
        end
        tick();
        tick();
        settle();
        check("wrap_drain_count", dbg_count, 0);
        check("wrap_drain_head", dbg_head, 15);
        check("wrap_drain_tail", dbg_tail, 15);
        lane(0, 1'b1, 5'd0, 32'h400);
        lane(1, 1'b1, 5'd1, 32'h404);
        settle();
        check("wrap_psrc0", psrc[0], 15);
        check("wrap_psrc1", psrc[1], 0);
        tick();
        clr();
        for (int g = 1; g < 7; g++) alloc2(5'(2 * g), 5'(2 * g + 1));
        lane(0, 1'b1, 5'd14, 32'h500);
        tick();
        clr();
        settle();
        check("wrap_refill_tail", dbg_tail, 14);
        check("wrap_refill_count", dbg_count, 15);
        wb(0, 4'd15, 32'h1500);
        wb(1, 4'd0, 32'h1000);
        tick();
        clr();
        settle();
        check("wrap_retire_valid", retire_valid, 2'b11);
        check("wrap_retire_preg0", retire_preg[0], 15);
        check("wrap_retire_preg1", retire_preg[1], 0);
        check("wrap_retire_data0", retire_data[0], 32'h1500);
        check("wrap_retire_data1", retire_data[1], 32'h1000);
        check("wrap_retire_dst1", retire_dst[1], 1);
        tick();
        settle();
        check("wrap_after_count", dbg_count, 13);
        check("wrap_after_head", dbg_head, 1);

        // Reset while occupied
        do_reset();
        settle();
        check("midrst_count", dbg_count, 0);
        check("midrst_alloc_ready", alloc_ready, 1);
        check("midrst_retire", retire_valid, 0);

        // Full ROB, ignored group, then simultaneous alloc and retire at 14
        for (int g = 0; g < 8; g++) alloc2(5'(g), 5'(g + 8));
        settle();
        check("full_count", dbg_count, 16);
        check("full_alloc_ready", alloc_ready, 0);
        check("full_tail", dbg_tail, 0);
        alloc2(5'd30, 5'd31);
        settle();
        check("full_ignored_count", dbg_count, 16);
        check("full_ignored_tail", dbg_tail, 0);
        wb(0, 4'd0, 32'h5);
        wb(1, 4'd1, 32'h6);
        tick();
        clr();
        settle();
        check("full_retire_valid", retire_valid, 2'b11);
        check("full_still_blocked", alloc_ready, 0);
        tick();
        settle();
        check("full_count14", dbg_count, 14);
        check("full_head2", dbg_head, 2);
        wb(0, 4'd2, 32'h7);
        wb(1, 4'd3, 32'h8);
        tick();
        clr();
        lane(0, 1'b1, 5'd20, 32'h600);
        lane(1, 1'b1, 5'd21, 32'h604);
        settle();
        check("both_alloc_ready", alloc_ready, 1);
        check("both_retire_valid", retire_valid, 2'b11);
        check("both_psrc0", psrc[0], 0);
        check("both_psrc1", psrc[1], 1);
        tick();
        clr();
        settle();
        check("both_count14", dbg_count, 14);
        check("both_head4", dbg_head, 4);
        check("both_tail2", dbg_tail, 2);

        // Flush with completed head entries and live alloc/wb
        do_reset();
        alloc2(5'd1, 5'd2);
        alloc2(5'd3, 5'd4);
        alloc2(5'd5, 5'd6);
        wb(0, 4'd0, 32'h1);
        wb(1, 4'd1, 32'h2);
        tick();
        clr();
        settle();
        check("flush_pre_retire", retire_valid, 2'b11);
        check("flush_pre_count", dbg_count, 6);
        flush = 1'b1;
        lane(0, 1'b1, 5'd7, 32'h700);
        lane(1, 1'b1, 5'd8, 32'h704);
        wb(0, 4'd2, 32'h3);
        settle();
        check("flush_retire_valid", retire_valid, 0);
        tick();
        clr();
        lane(0, 1'b1, 5'd9, 32'h800);
        lane(1, 1'b1, 5'd10, 32'h804);
        settle();
        check("flush_count", dbg_count, 0);
        check("flush_psrc0", psrc[0], 0);
        check("flush_head", dbg_head, 0);
        check("flush_tail", dbg_tail, 0);
        check("flush_alloc_ready", alloc_ready, 1);
        check("flush_retire_after", retire_valid, 0);
        clr();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
